imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Owns the single port of the instruction memory and shares it between the IF-stage fetch path and a byte-serial boot loader, typically a UART RX byte stream.
- After reset, it holds the pipeline, receives a length-prefixed program, writes it word by word into instruction memory, then releases the pipeline to fetch.
- A reload request returns the block to loading at any time.

Parameters:
- ADDR_W, 9, word-address width of instruction memory; depth = 2^ADDR_W words.
- NOP_WORD, 32'h00000000, instruction returned to IF while the pipeline is held or the address is out of range.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  loader byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  block accepts a byte when rx_valid & rx_ready.
- reload_req  input  1  single-cycle pulse; restarts loading.
- if_addr  input  32  IF byte address (PC).
- if_instr  output  32  instruction to IF (combinational).
- cpu_hold  output  1  pipeline stall/hold while not RUN.
- mem_addr  output  ADDR_W  word address to memory.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory combinational read data at mem_addr.
- load_done  output  1  one-cycle pulse on entry to RUN.
- words_loaded  output  ADDR_W+1  number of words written in the last or current load.

Behaviour:
- States: HDR, LOAD, WRITE, RUN.
- Reset (async, rst_n=0): state=HDR; byte counter=0; word shift register=0; length=0; words_loaded=0; mem_we=0; load_done=0; cpu_hold=1; rx_ready=1.
- Byte assembly is big-endian: the first accepted byte of a word goes to bits [31:24], the fourth to [7:0]. The byte counter wraps 3->0.
- HDR:
  - rx_ready=1.
  - On the 4th accepted byte, length = assembled word.
  - If length==0, go to RUN; otherwise go to LOAD with words_loaded=0.
- LOAD:
  - rx_ready=1.
  - On the 4th accepted byte, register the word into mem_wdata and go to WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0.
  - mem_we=1 only if words_loaded < 2^ADDR_W; mem_addr=words_loaded[ADDR_W-1:0].
  - Words beyond depth are consumed but discarded (mem_we=0).
  - Counter: words_loaded increments, saturating at 2^ADDR_W. An internal received count always increments.
  - Exit: if received count == length, go to RUN; else go to LOAD.
- RUN:
  - rx_ready=0; cpu_hold=0.
  - mem_addr = if_addr[ADDR_W+1:2].
  - if_instr = mem_rdata if if_addr[31:ADDR_W+2]==0, else NOP_WORD.
  - if_addr[1:0] are ignored.
- load_done: asserted exactly one cycle, in the first RUN cycle.
- Outside RUN: if_instr=NOP_WORD; cpu_hold=1; mem_addr is driven by the loader (words_loaded in WRITE, otherwise held).
- mem_we is 0 in every state except WRITE.
- reload_req:
  - In any state, the next state is HDR with byte counter=0 and the partial word discarded. words_loaded is cleared on the next header completion, not at the reload itself.
  - reload_req has priority over a byte accepted in the same cycle; that byte is dropped.
  - In WRITE, the pending write still occurs that cycle.
- Latency:
  - Byte to memory write: the 4th byte of a word is accepted in cycle N; mem_we is high in cycle N+1.
  - Final write to cpu_hold deassert: 1 cycle.
- rx_valid while rx_ready=0 is ignored; the source must hold the byte.
- Arithmetic: the length field is the full 32 bits and is compared against a 32-bit received count, so a length larger than depth still completes after that many words.
- Reset asserted mid-load aborts immediately, with no write and no load_done.

Test Plan:
- Basic load:
  - Stimulus: reset, then bytes 00 00 00 02, 20 04 00 20, 20 05 00 00.
  - Required: mem_we pulses twice (addr 0 wdata 20040020; addr 1 wdata 20050000); load_done one cycle; cpu_hold falls; words_loaded=2.
- Fetch in RUN:
  - Stimulus: if_addr=0x4 and mem_rdata=20050000.
  - Required: mem_addr=1, if_instr=20050000.
  - Stimulus: if_addr=0x800 (ADDR_W=9).
  - Required: if_instr=00000000.
- Zero-length:
  - Stimulus: header 00 00 00 00.
  - Required: RUN next cycle; no mem_we; load_done pulses; words_loaded=0.
- Overflow (ADDR_W=2):
  - Stimulus: length=6 with 6 words.
  - Required: 4 writes (addr 0..3); words 5 and 6 consumed with mem_we=0; words_loaded=4; then RUN.
- Reload mid-load:
  - Stimulus: after 1 word plus 2 bytes, pulse reload_req, then send header 1 and one word AABBCCDD.
  - Required: the partial bytes are dropped; a single write to addr 0 with AABBCCDD; cpu_hold stays 1 until RUN.
- Hold and backpressure:
  - Required: during LOAD, if_instr=NOP_WORD for any if_addr; rx_ready=0 in WRITE and in RUN; rx_valid in RUN causes no state change.
  - Stimulus: async rst_n low mid-WRITE.
  - Required: mem_we drops immediately; state returns to HDR.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Instruction memory port owner: byte-serial boot loader, then IF fetch.
// Ports: rx_* byte stream in, reload_req, if_addr/if_instr, mem_* port, status.
module imem_boot_loader #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_instr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    HDR,
    LOAD,
    WRITE,
    RUN
  } state_t;

  state_t state, state_n;

  logic [1:0]  bcnt;
  logic [23:0] shreg;
  logic [31:0] len;
  logic [31:0] rcnt;
  logic [31:0] rcnt_n;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        rx_phase;
  logic        acc;
  logic        last;
  logic [31:0] word;
  logic        wl_full;
  logic        unused;

  assign rx_phase  = (state == HDR) || (state == LOAD);
  assign rx_ready  = rx_phase;
  // reload wins over a byte offered in the same cycle
  assign acc       = rx_valid & rx_phase & ~reload_req;
  assign last      = acc & (bcnt == 2'd3);
  assign word      = {shreg, rx_data};
  assign rcnt_n    = rcnt + 32'd1;
  // counter saturates at depth, so the top bit marks "memory full"
  assign wl_full   = words_loaded[ADDR_W];
  assign mem_wdata = wdata_q;
  assign load_done = done_q;
  assign unused    = &{1'b0, if_addr[1:0]};

  always_comb begin
    state_n  = state;
    cpu_hold = 1'b1;
    mem_we   = 1'b0;
    mem_addr = words_loaded[ADDR_W-1:0];
    if_instr = NOP_WORD;
    unique case (state)
      HDR: begin
        if (last) state_n = (word == 32'd0) ? RUN : LOAD;
      end
      LOAD: begin
        if (last) state_n = WRITE;
      end
      WRITE: begin
        mem_we  = ~wl_full;
        state_n = (rcnt_n == len) ? RUN : LOAD;
      end
      RUN: begin
        cpu_hold = 1'b0;
        mem_addr = if_addr[ADDR_W+1:2];
        if (if_addr[31:ADDR_W+2] == '0) if_instr = mem_rdata;
      end
      default: state_n = HDR;
    endcase
    if (reload_req) state_n = HDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR;
      bcnt         <= 2'd0;
      shreg        <= 24'd0;
      len          <= 32'd0;
      rcnt         <= 32'd0;
      wdata_q      <= 32'd0;
      words_loaded <= '0;
      done_q       <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state_n == RUN) && (state != RUN);
      if (reload_req) begin
        bcnt  <= 2'd0;
        shreg <= 24'd0;
      end else if (acc) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= word[23:0];
      end
      if (last && state == HDR) begin
        len          <= word;
        rcnt         <= 32'd0;
        words_loaded <= '0;
      end
      if (last && state == LOAD) wdata_q <= word;
      if (state == WRITE) begin
        rcnt <= rcnt_n;
        if (!wl_full) words_loaded <= words_loaded + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: two instances (depth 512, depth 4)
// fed the same byte stream, compared against a write-list reference model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        reload_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] mem_rdata = 32'd0;

  logic        rdy1, we1, hold1, ldo1;
  logic [31:0] ins1, wd1;
  logic [8:0]  ma1;
  logic [9:0]  wl1;
  logic        rdy2, we2, hold2, ldo2;
  logic [31:0] ins2, wd2;
  logic [1:0]  ma2;
  logic [2:0]  wl2;

  int checks = 0;
  int failures = 0;

  logic [63:0] q1[$];
  logic [63:0] q2[$];
  int          nld1 = 0;
  int          nld2 = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(9)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .reload_req(reload_req), .if_addr(if_addr),
    .if_instr(ins1), .cpu_hold(hold1), .mem_addr(ma1), .mem_we(we1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata), .load_done(ldo1),
    .words_loaded(wl1)
  );

  imem_boot_loader #(.ADDR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy2), .reload_req(reload_req), .if_addr(if_addr),
    .if_instr(ins2), .cpu_hold(hold2), .mem_addr(ma2), .mem_we(we2),
    .mem_wdata(wd2), .mem_rdata(mem_rdata), .load_done(ldo2),
    .words_loaded(wl2)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (we1) q1.push_back({23'd0, ma1, wd1});
      if (we2) q2.push_back({30'd0, ma2, wd2});
      if (ldo1) nld1++;
      if (ldo2) nld2++;
    end
  end

  task automatic clear_mon;
    q1.delete();
    q2.delete();
    nld1 = 0;
    nld2 = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rdy1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_byte_timeout got rx_ready=%b exp=1", rdy1);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_reload(input logic with_byte);
    @(negedge clk);
    reload_req = 1'b1;
    rx_valid   = with_byte;
    rx_data    = 8'hEE;
    @(posedge clk);
    #1;
    reload_req = 1'b0;
    rx_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if_addr = 32'd0;
    mem_rdata = 32'h12345678;
    #12;
    checks++;
    if ({hold1, rdy1, we1, ldo1} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=1100", {hold1, rdy1, we1, ldo1});
    end
    checks++;
    if (wl1 !== 10'd0 || wl2 !== 3'd0) begin
      failures++;
      $display("FAIL reset_wl got=%0d/%0d exp=0", wl1, wl2);
    end
    checks++;
    if (ins1 !== 32'd0 || hold2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_instr got=%h exp=0", ins1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_load;
    clear_mon();
    send_word(32'd2);
    send_word(32'h20040020);
    @(negedge clk);
    checks++;
    if (!(we1 === 1'b1 && ma1 === 9'd0 && wd1 === 32'h20040020)) begin
      failures++;
      $display("FAIL basic_w0 got=%b/%0d/%h exp=1/0/20040020", we1, ma1, wd1);
    end
    checks++;
    if (rdy1 !== 1'b0) begin
      failures++;
      $display("FAIL write_ready got=%b exp=0", rdy1);
    end
    send_word(32'h20050000);
    @(negedge clk);
    checks++;
    if (!(we1 === 1'b1 && ma1 === 9'd1 && wd1 === 32'h20050000)) begin
      failures++;
      $display("FAIL basic_w1 got=%b/%0d/%h exp=1/1/20050000", we1, ma1, wd1);
    end
    checks++;
    if (hold1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold_write got=%b exp=1", hold1);
    end
    @(negedge clk);
    checks++;
    if (!(hold1 === 1'b0 && ldo1 === 1'b1)) begin
      failures++;
      $display("FAIL basic_run got=%b/%b exp=0/1", hold1, ldo1);
    end
    @(negedge clk);
    checks++;
    if (ldo1 !== 1'b0 || nld1 !== 1) begin
      failures++;
      $display("FAIL basic_done_pulse got=%b/%0d exp=0/1", ldo1, nld1);
    end
    checks++;
    if (q1.size() !== 2 || wl1 !== 10'd2 || wl2 !== 3'd2) begin
      failures++;
      $display("FAIL basic_count got=%0d/%0d exp=2", q1.size(), wl1);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      if (i == 0) begin a = 32'h4; d = 32'h20050000; end
      else if (i == 1) a = 32'h800;
      else if (i % 3 == 0) a = $urandom_range(0, 15);
      else if (i % 3 == 1) a = $urandom_range(0, 4095);
      else a = $urandom;
      if_addr = a;
      mem_rdata = d;
      #1;
      checks++;
      if (ma1 !== 9'((a / 4) % 512) || ma2 !== 2'((a / 4) % 4)) begin
        failures++;
        $display("FAIL fetch_addr a=%h got=%0d/%0d", a, ma1, ma2);
      end
      checks++;
      if (ins1 !== ((a < 32'd2048) ? d : 32'd0)) begin
        failures++;
        $display("FAIL fetch_instr1 a=%h got=%h rd=%h", a, ins1, d);
      end
      checks++;
      if (ins2 !== ((a < 32'd16) ? d : 32'd0)) begin
        failures++;
        $display("FAIL fetch_instr2 a=%h got=%h rd=%h", a, ins2, d);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_length;
    pulse_reload(1'b0);
    clear_mon();
    checks++;
    if (wl1 !== 10'd2 || hold1 !== 1'b1) begin
      failures++;
      $display("FAIL zero_pre got=%0d/%b exp=2/1", wl1, hold1);
    end
    send_word(32'd0);
    @(negedge clk);
    checks++;
    if (!(hold1 === 1'b0 && ldo1 === 1'b1 && hold2 === 1'b0)) begin
      failures++;
      $display("FAIL zero_run got=%b/%b exp=0/1", hold1, ldo1);
    end
    checks++;
    if (wl1 !== 10'd0 || wl2 !== 3'd0 || q1.size() != 0) begin
      failures++;
      $display("FAIL zero_wl got=%0d/%0d exp=0", wl1, q1.size());
    end
  endtask

  task automatic test_random_load;
    logic [31:0] w[$];
    int len;
    int e2;
    for (int it = 0; it < 5; it++) begin
      len = (it == 0) ? 6 : $urandom_range(1, 7);
      e2 = (len < 4) ? len : 4;
      w.delete();
      for (int i = 0; i < len; i++) w.push_back($urandom);
      pulse_reload(1'b0);
      clear_mon();
      send_word(32'(len));
      foreach (w[i]) send_word(w[i]);
      repeat (3) @(negedge clk);
      checks++;
      if (q1.size() != len || q2.size() != e2) begin
        failures++;
        $display("FAIL rnd_nwrites got=%0d/%0d exp=%0d/%0d",
                 q1.size(), q2.size(), len, e2);
      end
      for (int i = 0; i < len && i < q1.size(); i++) begin
        checks++;
        if (q1[i] !== {32'(i), w[i]}) begin
          failures++;
          $display("FAIL rnd_w1 got=%h exp=%h", q1[i], {32'(i), w[i]});
        end
      end
      for (int i = 0; i < e2 && i < q2.size(); i++) begin
        checks++;
        if (q2[i] !== {32'(i), w[i]}) begin
          failures++;
          $display("FAIL rnd_w2 got=%h exp=%h", q2[i], {32'(i), w[i]});
        end
      end
      checks++;
      if (wl1 !== 10'(len) || wl2 !== 3'(e2)) begin
        failures++;
        $display("FAIL rnd_wl got=%0d/%0d exp=%0d/%0d", wl1, wl2, len, e2);
      end
      checks++;
      if (nld1 != 1 || nld2 != 1 || hold1 !== 1'b0 || hold2 !== 1'b0) begin
        failures++;
        $display("FAIL rnd_run got=%0d/%0d/%b exp=1/1/0", nld1, nld2, hold2);
      end
    end
  endtask

  task automatic test_reload_mid;
    pulse_reload(1'b0);
    clear_mon();
    send_word(32'd3);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    pulse_reload(1'b1);
    checks++;
    if (hold1 !== 1'b1 || rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL reload_hold got=%b/%b exp=1/1", hold1, rdy1);
    end
    send_word(32'd1);
    send_word(32'hAABBCCDD);
    checks++;
    if (hold1 !== 1'b1) begin
      failures++;
      $display("FAIL reload_hold2 got=%b exp=1", hold1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 2) begin
      failures++;
      $display("FAIL reload_nwrites got=%0d exp=2", q1.size());
    end else begin
      checks++;
      if (q1[0] !== {32'd0, 32'h11223344} || q1[1] !== {32'd0, 32'hAABBCCDD}) begin
        failures++;
        $display("FAIL reload_data got=%h/%h exp=0/11223344,0/aabbccdd",
                 q1[0], q1[1]);
      end
    end
    checks++;
    if (wl1 !== 10'd1 || nld1 != 1 || hold1 !== 1'b0) begin
      failures++;
      $display("FAIL reload_end got=%0d/%0d/%b exp=1/1/0", wl1, nld1, hold1);
    end
  endtask

  task automatic test_hold_backpressure;
    pulse_reload(1'b0);
    clear_mon();
    send_word(32'd2);
    for (int i = 0; i < 4; i++) begin
      if_addr = (i == 0) ? 32'd0 : $urandom;
      mem_rdata = $urandom | 32'h1;
      #1;
      checks++;
      if (ins1 !== 32'd0 || ins2 !== 32'd0 || hold1 !== 1'b1) begin
        failures++;
        $display("FAIL load_nop a=%h got=%h/%b exp=0/1", if_addr, ins1, hold1);
      end
    end
    send_word(32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (we1 !== 1'b1 || rdy1 !== 1'b0) begin
      failures++;
      $display("FAIL bp_write got=%b/%b exp=1/0", we1, rdy1);
    end
    send_word(32'h0000BEEF);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++;
    if (rdy1 !== 1'b0 || hold1 !== 1'b0 || q1.size() != 2 || wl1 !== 10'd2) begin
      failures++;
      $display("FAIL run_ignore got=%b/%b/%0d/%0d exp=0/0/2/2",
               rdy1, hold1, q1.size(), wl1);
    end
  endtask

  task automatic test_async_reset;
    pulse_reload(1'b0);
    clear_mon();
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (we1 !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got=%b exp=1", we1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we1, hold1, rdy1, ldo1} !== 4'b0110 || wl1 !== 10'd0) begin
      failures++;
      $display("FAIL arst_now got=%b/%0d exp=0110/0", {we1, hold1, rdy1, ldo1}, wl1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    send_word(32'd1);
    send_word(32'h0BADF00D);
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 1 || nld1 != 1 || wl1 !== 10'd1) begin
      failures++;
      $display("FAIL arst_after got=%0d/%0d/%0d exp=1/1/1", q1.size(), nld1, wl1);
    end else begin
      checks++;
      if (q1[0] !== {32'd0, 32'h0BADF00D}) begin
        failures++;
        $display("FAIL arst_data got=%h exp=0/0badf00d", q1[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_fetch();
    test_zero_length();
    test_random_load();
    test_reload_mid();
    test_hold_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
